branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor that replaces the fixed predict/repair logic in the fetch stage.
- Fetch looks it up combinationally with the current PC and gets a taken/target guess.
- The resolve point (EX/MEM boundary) trains it with the actual outcome.
- Tagged BTB plus saturating counters; optional gshare indexing; registered misprediction pulse.

---
 rtl/bp_pkg.sv | 53 +++++
 rtl/bp_table.sv | 78 +++++++
 rtl/branch_predictor.sv | 141 ++++++++++++++
 tb/tb_branch_predictor.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the branch predictor.
// Counter constants, saturating arithmetic and index/tag extraction live
// here so the table and the top agree on a single definition.
`timescale 1ns/1ps
package bp_pkg;

  // What an update does to the addressed table entry
  typedef enum logic [1:0] {
    BP_ACT_NONE,   // miss and not taken: table untouched
    BP_ACT_TRAIN,  // hit: adjust counter, refresh target when taken
    BP_ACT_ALLOC   // miss and taken: overwrite the entry
  } bp_action_e;

  // Saturation ceiling of a cnt_bits-wide counter
  function automatic int unsigned cnt_max(input int unsigned cnt_bits);
    return (32'd1 << cnt_bits) - 32'd1;
  endfunction

  // Weakly-taken: smallest value with the MSB set
  function automatic int unsigned cnt_wt(input int unsigned cnt_bits);
    return 32'd1 << (cnt_bits - 32'd1);
  endfunction

  // Weakly-not-taken: largest value with the MSB clear
  function automatic int unsigned cnt_wnt(input int unsigned cnt_bits);
    return cnt_wt(cnt_bits) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned cnt_bits);
    return (v >= cnt_max(cnt_bits)) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? v : v - 32'd1;
  endfunction

  // Word index, folded with global history (ghr is zero when bimodal)
  function automatic logic [63:0] bp_index(input logic [63:0] pc, input logic [63:0] ghr,
                                           input int unsigned idx_bits);
    logic [63:0] mask;
    mask = (64'd1 << idx_bits) - 64'd1;
    return ((pc >> 2) ^ ghr) & mask;
  endfunction

  // Tag bits sit directly above the index bits
  function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int unsigned idx_bits,
                                         input int unsigned tag_bits);
    logic [63:0] mask;
    mask = (64'd1 << tag_bits) - 64'd1;
    return (pc >> (idx_bits + 32'd2)) & mask;
  endfunction

endpackage

// File: rtl/bp_table.sv
// bp_table: ENTRIES-deep predictor storage. Asynchronous read for the fetch
// lookup and for the resolve-side read-modify-write, one synchronous write.
// Valid bits and counters are cleared on reset; tags/targets are not, since
// a cleared valid bit hides them.
`timescale 1ns/1ps
module bp_table
  import bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8,
  parameter int CNT_BITS = 2,
  localparam int IDX     = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX-1:0]      rd_idx,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [XLEN-1:0]     rd_target,
  output logic [CNT_BITS-1:0] rd_cnt,
  input  logic [IDX-1:0]      up_idx,
  output logic                up_valid,
  output logic [TAG_BITS-1:0] up_tag,
  output logic [XLEN-1:0]     up_target,
  output logic [CNT_BITS-1:0] up_cnt,
  input  logic                we,
  input  logic [IDX-1:0]      wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [XLEN-1:0]     wr_target,
  input  logic [CNT_BITS-1:0] wr_cnt
);

  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'(cnt_wnt(CNT_BITS));

  logic [ENTRIES-1:0]  valid_reg;
  logic [CNT_BITS-1:0] cnt_reg    [ENTRIES];
  logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
  logic [XLEN-1:0]     target_mem [ENTRIES];
  logic [ENTRIES-1:0]  wr_sel;

  // One-hot decode of the write address
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_sel
    assign wr_sel[gi] = we && (wr_idx == IDX'(gi));
  end

  // Valid bits and counters: cleared by reset, which overrides any write
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (reset) begin
        valid_reg[i] <= 1'b0;
        cnt_reg[i]   <= CNT_WNT;
      end else if (wr_sel[i]) begin
        valid_reg[i] <= 1'b1;
        cnt_reg[i]   <= wr_cnt;
      end
    end
  end

  // Tag and target payload: plain write-only storage, no reset
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      tag_mem[wr_idx]    <= wr_tag;
      target_mem[wr_idx] <= wr_target;
    end
  end

  assign rd_valid  = valid_reg[rd_idx];
  assign rd_tag    = tag_mem[rd_idx];
  assign rd_target = target_mem[rd_idx];
  assign rd_cnt    = cnt_reg[rd_idx];

  assign up_valid  = valid_reg[up_idx];
  assign up_tag    = tag_mem[up_idx];
  assign up_target = target_mem[up_idx];
  assign up_cnt    = cnt_reg[up_idx];

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: tagged BTB with saturating direction counters and
// optional gshare indexing (GHR_BITS > 0). Lookup is combinational; training
// happens at the resolve point and is visible from the next cycle.
// Build option: define BP_PERF_EN to enable the branch/mispredict counters;
// otherwise both counter outputs are tied to zero.
`timescale 1ns/1ps
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8,
  parameter int CNT_BITS = 2,
  parameter int GHR_BITS = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            update_valid_i,
  input  logic [XLEN-1:0] update_pc_i,
  input  logic            update_is_cond_i,
  input  logic            update_taken_i,
  input  logic [XLEN-1:0] update_target_i,
  input  logic            update_pred_taken_i,
  input  logic [XLEN-1:0] update_pred_target_i,
  output logic            mispred_o,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispred_cnt_o
);

  localparam int IDX = $clog2(ENTRIES);
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(cnt_wt(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(cnt_max(CNT_BITS));

  logic [63:0]         ghr_hist;
  logic [IDX-1:0]      lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic                rd_valid, up_valid;
  logic [TAG_BITS-1:0] rd_tag, up_tag_rd;
  logic [XLEN-1:0]     rd_target, up_target;
  logic [CNT_BITS-1:0] rd_cnt, up_cnt;
  logic                lk_hit, up_hit;
  bp_action_e          act;
  logic [CNT_BITS-1:0] wr_cnt;
  logic [XLEN-1:0]     wr_target;
  logic                mispred_reg, mispred_next;

  // Global history: shifts on resolved conditional branches only
  if (GHR_BITS > 0) begin : g_ghr
    logic [GHR_BITS-1:0] ghr_reg, ghr_next;
    assign ghr_next = GHR_BITS'({ghr_reg, update_taken_i});
    always_ff @(posedge clk) begin
      if (reset) ghr_reg <= '0;
      else if (update_valid_i && update_is_cond_i) ghr_reg <= ghr_next;
    end
    assign ghr_hist = 64'(ghr_reg);
  end else begin : g_bimodal
    assign ghr_hist = '0;
  end

  assign lk_idx = IDX'(bp_index(64'(lookup_pc_i), ghr_hist, IDX));
  assign lk_tag = TAG_BITS'(bp_tag(64'(lookup_pc_i), IDX, TAG_BITS));
  assign up_idx = IDX'(bp_index(64'(update_pc_i), ghr_hist, IDX));
  assign up_tag = TAG_BITS'(bp_tag(64'(update_pc_i), IDX, TAG_BITS));

  bp_table #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CNT_BITS(CNT_BITS)
  ) u_table (
    .clk(clk), .reset(reset),
    .rd_idx(lk_idx), .rd_valid(rd_valid), .rd_tag(rd_tag),
    .rd_target(rd_target), .rd_cnt(rd_cnt),
    .up_idx(up_idx), .up_valid(up_valid), .up_tag(up_tag_rd),
    .up_target(up_target), .up_cnt(up_cnt),
    .we(act != BP_ACT_NONE), .wr_idx(up_idx), .wr_tag(up_tag),
    .wr_target(wr_target), .wr_cnt(wr_cnt)
  );

  // Fetch side: taken only on a tag hit whose counter MSB is set
  assign lk_hit        = rd_valid && (rd_tag == lk_tag);
  assign pred_taken_o  = lk_hit && rd_cnt[CNT_BITS-1];
  assign pred_target_o = pred_taken_o ? rd_target : lookup_pc_i + XLEN'(4);

  assign up_hit = up_valid && (up_tag_rd == up_tag);

  // Resolve side: choose train / allocate and the new counter and target
  always_comb begin
    act       = BP_ACT_NONE;
    wr_cnt    = up_cnt;
    wr_target = up_target;
    if (update_valid_i) begin
      if (up_hit) begin
        act = BP_ACT_TRAIN;
        if (!update_is_cond_i) wr_cnt = CNT_MAX;
        else if (update_taken_i) wr_cnt = CNT_BITS'(sat_inc(32'(up_cnt), CNT_BITS));
        else wr_cnt = CNT_BITS'(sat_dec(32'(up_cnt)));
        if (update_taken_i) wr_target = update_target_i;
      end else if (update_taken_i) begin
        act       = BP_ACT_ALLOC;
        wr_cnt    = update_is_cond_i ? CNT_WT : CNT_MAX;
        wr_target = update_target_i;
      end
    end
  end

  // Wrong direction, or right "taken" direction with the wrong target
  assign mispred_next = update_valid_i &&
                        ((update_taken_i != update_pred_taken_i) ||
                         (update_taken_i && (update_target_i != update_pred_target_i)));

  // Registered one-cycle misprediction pulse
  always_ff @(posedge clk) begin
    if (reset) mispred_reg <= 1'b0;
    else mispred_reg <= mispred_next;
  end
  assign mispred_o = mispred_reg;

`ifdef BP_PERF_EN
  logic [31:0] branch_cnt_reg, mispred_cnt_reg;

  // Saturating event counters; mispredict count lands with the pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_reg  <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      if (update_valid_i && (branch_cnt_reg != 32'hFFFF_FFFF))
        branch_cnt_reg <= branch_cnt_reg + 32'd1;
      if (mispred_next && (mispred_cnt_reg != 32'hFFFF_FFFF))
        mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
    end
  end
  assign branch_cnt_o  = branch_cnt_reg;
  assign mispred_cnt_o = mispred_cnt_reg;
`else
  assign branch_cnt_o  = 32'd0;
  assign mispred_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scenarios plus random traffic, checked
// against a table-level behavioural model. Two instances share stimulus:
// u_dut0 is bimodal (default), u_dut1 uses 4 bits of global history.
`timescale 1ns/1ps
module tb_branch_predictor;

`ifdef BP_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc_i, update_pc_i, update_target_i, update_pred_target_i;
  logic        update_valid_i, update_is_cond_i, update_taken_i, update_pred_taken_i;
  logic        pt0, pt1, mp0, mp1;
  logic [31:0] ptg0, ptg1, bc0, bc1, mc0, mc1;

  always #5 clk = ~clk;

  branch_predictor u_dut0 (
    .clk(clk), .reset(reset), .lookup_pc_i(lookup_pc_i),
    .pred_taken_o(pt0), .pred_target_o(ptg0),
    .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
    .update_is_cond_i(update_is_cond_i), .update_taken_i(update_taken_i),
    .update_target_i(update_target_i), .update_pred_taken_i(update_pred_taken_i),
    .update_pred_target_i(update_pred_target_i),
    .mispred_o(mp0), .branch_cnt_o(bc0), .mispred_cnt_o(mc0)
  );

  branch_predictor #(.GHR_BITS(4)) u_dut1 (
    .clk(clk), .reset(reset), .lookup_pc_i(lookup_pc_i),
    .pred_taken_o(pt1), .pred_target_o(ptg1),
    .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
    .update_is_cond_i(update_is_cond_i), .update_taken_i(update_taken_i),
    .update_target_i(update_target_i), .update_pred_taken_i(update_pred_taken_i),
    .update_pred_target_i(update_pred_target_i),
    .mispred_o(mp1), .branch_cnt_o(bc1), .mispred_cnt_o(mc1)
  );

  int n_vec = 0;
  int n_miss = 0;

  // Reference model: 16 entries per instance, 2-bit counters as integers 0..3
  bit          m_valid  [2][16];
  int unsigned m_tag    [2][16];
  logic [31:0] m_target [2][16];
  int          m_cnt    [2][16];
  int unsigned m_ghr    [2];
  int unsigned m_bc, m_mc;

  // Observed (o_) and expected (e_) values of the last applied cycle
  logic        o_tk [2];
  logic [31:0] o_tg [2];
  logic        o_mp [2];
  logic [31:0] o_bc [2], o_mc [2];
  bit          e_tk [2];
  logic [31:0] e_tg [2];
  bit          e_mp;
  logic [31:0] e_bc, e_mc;

  function automatic int midx(int c, logic [31:0] pc);
    return int'(((pc >> 2) ^ m_ghr[c]) & 32'd15);
  endfunction

  function automatic int unsigned mtag(logic [31:0] pc);
    return (pc >> 6) & 32'd255;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[c][i] = 1'b0;
        m_cnt[c][i]   = 1;
      end
      m_ghr[c] = 0;
    end
    m_bc = 0;
    m_mc = 0;
  endfunction

  function automatic void model_predict(int c, logic [31:0] pc, output bit tk, output logic [31:0] tg);
    int i;
    bit hit;
    i   = midx(c, pc);
    hit = m_valid[c][i] && (m_tag[c][i] == mtag(pc));
    tk  = hit && (m_cnt[c][i] >= 2);
    tg  = tk ? m_target[c][i] : pc + 32'd4;
  endfunction

  function automatic void model_update(int c, logic [31:0] pc, bit cond, bit tk, logic [31:0] tg);
    int i;
    bit hit;
    i   = midx(c, pc);
    hit = m_valid[c][i] && (m_tag[c][i] == mtag(pc));
    if (hit) begin
      if (!cond) m_cnt[c][i] = 3;
      else if (tk) m_cnt[c][i] = (m_cnt[c][i] < 3) ? m_cnt[c][i] + 1 : 3;
      else m_cnt[c][i] = (m_cnt[c][i] > 0) ? m_cnt[c][i] - 1 : 0;
      if (tk) m_target[c][i] = tg;
    end else if (tk) begin
      m_valid[c][i]  = 1'b1;
      m_tag[c][i]    = mtag(pc);
      m_target[c][i] = tg;
      m_cnt[c][i]    = cond ? 2 : 3;
    end
    if (c == 1 && cond) m_ghr[c] = ((m_ghr[c] << 1) | 32'(tk)) & 32'd15;
  endfunction

  // Drive one cycle, sample lookup before the edge and registered outputs after
  task automatic apply(input bit rst, input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                       input bit ucond, input bit utk, input logic [31:0] utg,
                       input bit uptk, input logic [31:0] uptg);
    @(negedge clk);
    reset = rst; lookup_pc_i = lpc;
    update_valid_i = uv; update_pc_i = upc; update_is_cond_i = ucond;
    update_taken_i = utk; update_target_i = utg;
    update_pred_taken_i = uptk; update_pred_target_i = uptg;
    #1;
    o_tk[0] = pt0; o_tg[0] = ptg0; o_tk[1] = pt1; o_tg[1] = ptg1;
    for (int c = 0; c < 2; c++) model_predict(c, lpc, e_tk[c], e_tg[c]);
    e_mp = !rst && uv && ((utk != uptk) || (utk && (utg != uptg)));
    if (rst) model_reset();
    else if (uv) begin
      for (int c = 0; c < 2; c++) model_update(c, upc, ucond, utk, utg);
      m_bc++;
      if (e_mp) m_mc++;
    end
    e_bc = PERF ? m_bc : 32'd0;
    e_mc = PERF ? m_mc : 32'd0;
    @(posedge clk);
    #1;
    o_mp[0] = mp0; o_mp[1] = mp1;
    o_bc[0] = bc0; o_bc[1] = bc1; o_mc[0] = mc0; o_mc[1] = mc1;
  endtask

  task automatic test_reset();
    // Reset with a mispredicting update presented: reset must win
    apply(1, 32'h100, 1, 32'h100, 1, 1, 32'h80, 0, 32'h104);
    for (int c = 0; c < 2; c++) begin
      n_vec++;
      if (o_mp[c] !== 1'b0 || o_bc[c] !== 32'd0 || o_mc[c] !== 32'd0) begin
        n_miss++;
        $display("FAIL reset_regs dut%0d: mispred=%b branch=%0d mispred_cnt=%0d, want 0/0/0", c, o_mp[c], o_bc[c], o_mc[c]);
      end
    end
    apply(0, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    n_vec++;
    if (o_tk[0] !== 1'b0 || o_tg[0] !== 32'h104) begin
      n_miss++;
      $display("FAIL reset_lookup: taken=%b target=%h, want 0/00000104", o_tk[0], o_tg[0]);
    end
    apply(0, 32'hFFFF_FFFC, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    n_vec++;
    if (o_tk[0] !== 1'b0 || o_tg[0] !== 32'h0) begin
      n_miss++;
      $display("FAIL pc_wrap: taken=%b target=%h, want 0/00000000", o_tk[0], o_tg[0]);
    end
  endtask

  task automatic test_train();
    apply(0, 32'h100, 1, 32'h100, 1, 1, 32'h80, 0, 32'h104);
    n_vec++;
    if (o_mp[0] !== 1'b1 || o_bc[0] !== (PERF ? 32'd1 : 32'd0) || o_mc[0] !== (PERF ? 32'd1 : 32'd0)) begin
      n_miss++;
      $display("FAIL train_mispred: mispred=%b branch=%0d mispred_cnt=%0d, want 1/%0d/%0d", o_mp[0], o_bc[0], o_mc[0], PERF, PERF);
    end
    apply(0, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    n_vec++;
    if (o_tk[0] !== 1'b1 || o_tg[0] !== 32'h80 || o_mp[0] !== 1'b0) begin
      n_miss++;
      $display("FAIL train_lookup: taken=%b target=%h mispred=%b, want 1/00000080/0", o_tk[0], o_tg[0], o_mp[0]);
    end
  endtask

  task automatic test_saturate();
    bit tk;
    logic [31:0] tg;
    // Three not-taken then one taken: counter 2->1->0->0->1, never taken
    for (int k = 0; k < 4; k++) begin
      model_predict(0, 32'h100, tk, tg);
      apply(0, 32'h100, 1, 32'h100, 1, (k == 3), 32'h80, tk, tg);
      apply(0, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
      n_vec++;
      if (o_tk[0] !== 1'b0 || o_tg[0] !== 32'h104) begin
        n_miss++;
        $display("FAIL saturate_step%0d: taken=%b target=%h, want 0/00000104", k, o_tk[0], o_tg[0]);
      end
    end
  endtask

  task automatic test_alias();
    apply(0, 32'h100, 1, 32'h100, 1, 1, 32'h80, 0, 32'h104);  // counter back to 2
    apply(0, 32'h500, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    n_vec++;
    if (o_tk[0] !== 1'b0 || o_tg[0] !== 32'h504) begin
      n_miss++;
      $display("FAIL alias_lookup: taken=%b target=%h, want 0/00000504", o_tk[0], o_tg[0]);
    end
    apply(0, 32'h100, 1, 32'h500, 1, 1, 32'h900, 0, 32'h504);
    n_vec++;
    if (o_tk[0] !== 1'b1 || o_tg[0] !== 32'h80) begin
      n_miss++;
      $display("FAIL alias_before: taken=%b target=%h, want 1/00000080", o_tk[0], o_tg[0]);
    end
    apply(0, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    n_vec++;
    if (o_tk[0] !== 1'b0 || o_tg[0] !== 32'h104) begin
      n_miss++;
      $display("FAIL alias_evicted: taken=%b target=%h, want 0/00000104", o_tk[0], o_tg[0]);
    end
    apply(0, 32'h500, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    n_vec++;
    if (o_tk[0] !== 1'b1 || o_tg[0] !== 32'h900) begin
      n_miss++;
      $display("FAIL alias_new: taken=%b target=%h, want 1/00000900", o_tk[0], o_tg[0]);
    end
  endtask

  task automatic test_back_to_back();
    // Same-cycle lookup sees the pre-update table
    apply(0, 32'h200, 1, 32'h200, 1, 1, 32'h280, 0, 32'h204);
    n_vec++;
    if (o_tk[0] !== 1'b0 || o_tg[0] !== 32'h204 || o_mp[0] !== 1'b1) begin
      n_miss++;
      $display("FAIL same_cycle: taken=%b target=%h mispred=%b, want 0/00000204/1", o_tk[0], o_tg[0], o_mp[0]);
    end
    apply(0, 32'h200, 1, 32'h300, 0, 1, 32'h40, 1, 32'h40);
    n_vec++;
    if (o_tk[0] !== 1'b1 || o_tg[0] !== 32'h280 || o_mp[0] !== 1'b0) begin
      n_miss++;
      $display("FAIL next_cycle: taken=%b target=%h mispred=%b, want 1/00000280/0", o_tk[0], o_tg[0], o_mp[0]);
    end
    apply(0, 32'h300, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    n_vec++;
    if (o_tk[0] !== 1'b1 || o_tg[0] !== 32'h40) begin
      n_miss++;
      $display("FAIL jump_lookup: taken=%b target=%h, want 1/00000040", o_tk[0], o_tg[0]);
    end
  endtask

  task automatic test_ghr();
    apply(1, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    apply(0, 32'h0, 1, 32'h118, 0, 1, 32'h7C0, 0, 32'h11C);  // jump: no history shift
    apply(0, 32'h0, 1, 32'h100, 1, 1, 32'h80, 0, 32'h104);
    apply(0, 32'h0, 1, 32'h100, 1, 1, 32'h80, 0, 32'h104);
    apply(0, 32'h0, 1, 32'h100, 1, 0, 32'h80, 0, 32'h104);
    apply(0, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    n_vec++;
    if (o_tk[1] !== 1'b1 || o_tg[1] !== 32'h7C0) begin
      n_miss++;
      $display("FAIL ghr_index: taken=%b target=%h, want 1/000007c0", o_tk[1], o_tg[1]);
    end
    n_vec++;
    if (o_tk[0] !== 1'b1 || o_tg[0] !== 32'h80) begin
      n_miss++;
      $display("FAIL ghr_bimodal: taken=%b target=%h, want 1/00000080", o_tk[0], o_tg[0]);
    end
    apply(1, 32'h100, 1, 32'h100, 1, 1, 32'h84, 0, 32'h104);
    n_vec++;
    if (o_mp[1] !== 1'b0 || o_bc[1] !== 32'd0 || o_mc[1] !== 32'd0) begin
      n_miss++;
      $display("FAIL ghr_reset_regs: mispred=%b branch=%0d mispred_cnt=%0d, want 0/0/0", o_mp[1], o_bc[1], o_mc[1]);
    end
    apply(0, 32'h118, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      n_vec++;
      if (o_tk[c] !== 1'b0 || o_tg[c] !== 32'h11C) begin
        n_miss++;
        $display("FAIL ghr_reset_lookup dut%0d: taken=%b target=%h, want 0/0000011c", c, o_tk[c], o_tg[c]);
      end
    end
    apply(0, 32'h0, 1, 32'h100, 0, 1, 32'h44, 1, 32'h44);
    apply(0, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    n_vec++;
    if (o_tk[1] !== 1'b1 || o_tg[1] !== 32'h44) begin
      n_miss++;
      $display("FAIL ghr_cleared: taken=%b target=%h, want 1/00000044", o_tk[1], o_tg[1]);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(4, 7)) << 6) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic test_random();
    bit rst, uv, cond, tk, ptk;
    logic [31:0] lpc, upc, tg, ptg;
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 59) == 0);
      uv   = ($urandom_range(0, 3) != 0);
      cond = ($urandom_range(0, 4) != 0);
      tk   = cond ? bit'($urandom_range(0, 1)) : 1'b1;
      lpc  = rand_pc();
      upc  = rand_pc();
      tg   = {16'h0, 16'($urandom)} & 32'hFFFC;
      if ($urandom_range(0, 1) == 1) model_predict(0, upc, ptk, ptg);
      else begin
        ptk = bit'($urandom_range(0, 1));
        ptg = ($urandom_range(0, 1) == 1) ? tg : upc + 32'd4;
      end
      apply(rst, lpc, uv, upc, cond, tk, tg, ptk, ptg);
      for (int c = 0; c < 2; c++) begin
        n_vec++;
        if (o_tk[c] !== e_tk[c] || o_tg[c] !== e_tg[c]) begin
          n_miss++;
          $display("FAIL rand_lookup dut%0d n=%0d pc=%h: taken=%b target=%h, want %b/%h", c, n, lpc, o_tk[c], o_tg[c], e_tk[c], e_tg[c]);
        end
        n_vec++;
        if (o_mp[c] !== e_mp || o_bc[c] !== e_bc || o_mc[c] !== e_mc) begin
          n_miss++;
          $display("FAIL rand_regs dut%0d n=%0d: mispred=%b branch=%0d mispred_cnt=%0d, want %b/%0d/%0d", c, n, o_mp[c], o_bc[c], o_mc[c], e_mp, e_bc, e_mc);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; lookup_pc_i = '0;
    update_valid_i = 1'b0; update_pc_i = '0; update_is_cond_i = 1'b0;
    update_taken_i = 1'b0; update_target_i = '0;
    update_pred_taken_i = 1'b0; update_pred_target_i = '0;
    model_reset();
    test_reset();
    test_train();
    test_saturate();
    test_alias();
    test_back_to_back();
    test_ghr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
